mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_pkg.sv | 168 ++++++++++++++++
 rtl/mc_control_fsm_if.sv | 37 +++
 rtl/mc_wait_counter.sv | 28 ++
 rtl/mc_control_fsm.sv | 133 +++++++++++++
 tb/tb_mc_control_fsm.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared opcodes, functs, state encodings and select values
// for the multicycle controller and its datapath.
package mc_control_fsm_pkg;

  localparam int CNT_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_ITYPE = 2'd3;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REG    = 2'd3;
  localparam logic [2:0] SRCB_B     = 3'd0;
  localparam logic [2:0] SRCB_4     = 3'd1;
  localparam logic [2:0] SRCB_IMM   = 3'd2;
  localparam logic [2:0] SRCB_SHIMM = 3'd3;
  localparam logic [2:0] SRCB_A     = 3'd4;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE,
    S_EXEC_R, S_EXEC_I, S_EXEC_MEM, S_MEM_RD,
    S_MEM_WR, S_MEM_WAIT, S_WB_R, S_WB_I,
    S_WB_MEM, S_BRANCH, S_JUMP, S_JAL_WB,
    S_JR, S_HALT
  } state_t;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [2:0] alu_src_b;
  } ctrl_t;

  function automatic logic is_shift(logic [5:0] fn);
    return fn inside {F_SLL, F_SRL, F_SRA};
  endfunction

  function automatic logic alu_funct_ok(logic [5:0] fn);
    return fn inside {F_SLL, F_SRL, F_SRA, F_ADD,
      F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR,
      F_NOR, F_SLT, F_SLTU};
  endfunction

  function automatic logic is_itype(logic [5:0] op);
    return op inside {OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI};
  endfunction

  function automatic ctrl_t decode_ctrl(
    state_t s, logic [5:0] op, logic [5:0] fn);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_4;
      end
      S_DECODE: c.alu_src_b = SRCB_SHIMM;
      S_EXEC_R: begin
        c.alu_op = ALU_FUNCT;
        if (is_shift(fn)) begin
          c.alu_src_a = SRCA_SHAMT;
          c.alu_src_b = SRCB_A;
        end else begin
          c.alu_src_a = SRCA_A;
          c.alu_src_b = SRCB_B;
        end
      end
      S_WB_R: begin
        c.reg_dst   = DST_RD;
        c.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ITYPE;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_EXEC_MEM: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD:   c.iord = 1'b1;
      S_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_MEM_WAIT: c.iord = 1'b1;
      S_WB_MEM: begin
        c.mem_to_reg = M2R_MDR;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_A;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALU_SUB;
        c.pc_source     = PCS_ALUOUT;
        c.pc_write_cond = 1'b1;
        c.branch_ne     = (op == OP_BNE);
      end
      S_JUMP: begin
        c.pc_source = PCS_JUMP;
        c.pc_write  = 1'b1;
      end
      S_JAL_WB: begin
        c.reg_dst    = DST_RA;
        c.mem_to_reg = M2R_PC;
        c.reg_write  = 1'b1;
      end
      S_JR: begin
        c.pc_source = PCS_REG;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller-to-datapath bundle: instruction fields in,
// control strobes and selects out.
interface mc_control_fsm_if;
  logic [5:0] Op_code;
  logic [5:0] Funct;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       illegal_op;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [2:0] ALUSrcB;
  logic [4:0] state_dbg;

  modport master (
    input  Op_code, Funct,
    output MemWrite, IRWrite, RegWrite, PCWrite,
    output PCWriteCond, BranchNe, IorD, illegal_op,
    output RegDst, MemtoReg, ALUSrcA, ALUOp,
    output PCSource, ALUSrcB, state_dbg
  );

  modport slave (
    output Op_code, Funct,
    input  MemWrite, IRWrite, RegWrite, PCWrite,
    input  PCWriteCond, BranchNe, IorD, illegal_op,
    input  RegDst, MemtoReg, ALUSrcA, ALUOp,
    input  PCSource, ALUSrcB, state_dbg
  );
endinterface

// File: rtl/mc_wait_counter.sv
// Saturating down-counter timing memory wait states;
// done is high while the count is zero.
module mc_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with registered
// Moore outputs and configurable memory wait states.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MEM_WAIT        = 1,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input logic           clk,
  input logic           rst,
  mc_control_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] RELOAD =
    (MEM_WAIT > 0) ? CNT_W'(MEM_WAIT - 1) : '0;
  localparam logic SKIP_WAIT = (MEM_WAIT == 0);
  localparam logic HALT_ILL  = (HALT_ON_ILLEGAL != 0);

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl_q;
  logic       ill_q;
  logic       ill;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_done;
  logic [5:0] op;
  logic [5:0] fn;

  assign op = bus.Op_code;
  assign fn = bus.Funct;

  mc_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    nxt = state;
    ill = 1'b0;
    unique case (state)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: nxt = SKIP_WAIT ? S_DECODE
                               : S_FETCH_WAIT;
      S_FETCH_WAIT: if (cnt_done) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_RTYPE && fn == F_JR):
            nxt = S_JR;
          (op == OP_RTYPE && alu_funct_ok(fn)):
            nxt = S_EXEC_R;
          is_itype(op):
            nxt = S_EXEC_I;
          (op == OP_LW || op == OP_SW):
            nxt = S_EXEC_MEM;
          (op == OP_BEQ || op == OP_BNE):
            nxt = S_BRANCH;
          (op == OP_J):
            nxt = S_JUMP;
          (op == OP_JAL):
            nxt = S_JAL_WB;
          default: begin
            ill = 1'b1;
            nxt = HALT_ILL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXEC_R: nxt = S_WB_R;
      S_EXEC_I: nxt = S_WB_I;
      S_EXEC_MEM:
        nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: nxt = SKIP_WAIT ? S_WB_MEM
                                : S_MEM_WAIT;
      S_MEM_WR: nxt = SKIP_WAIT ? S_FETCH
                                : S_MEM_WAIT;
      // the instruction register is stable through
      // the access, so Op_code still tells LW from SW
      S_MEM_WAIT:
        if (cnt_done)
          nxt = (op == OP_LW) ? S_WB_MEM : S_FETCH;
      S_WB_R:   nxt = S_FETCH;
      S_WB_I:   nxt = S_FETCH;
      S_WB_MEM: nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_JAL_WB: nxt = S_JUMP;
      S_JR:     nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end

  always_comb begin
    cnt_load =
      (nxt == S_FETCH_WAIT && state != S_FETCH_WAIT) ||
      (nxt == S_MEM_WAIT && state != S_MEM_WAIT);
    cnt_dec =
      (state == S_FETCH_WAIT || state == S_MEM_WAIT) &&
      !cnt_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= decode_ctrl(nxt, op, fn);
      if (ill) ill_q <= 1'b1;
    end
  end

  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.IRWrite     = ctrl_q.ir_write;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.PCWrite     = ctrl_q.pc_write;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.BranchNe    = ctrl_q.branch_ne;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.illegal_op  = ill_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: three instances with
// MEM_WAIT of 1, 3 and 0 share clock, reset and opcode.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = '0;
  logic [5:0] fn  = '0;
  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if if1 ();
  mc_control_fsm_if if3 ();
  mc_control_fsm_if if0 ();

  assign if1.Op_code = op;
  assign if1.Funct   = fn;
  assign if3.Op_code = op;
  assign if3.Funct   = fn;
  assign if0.Op_code = op;
  assign if0.Funct   = fn;

  mc_control_fsm #(.MEM_WAIT(1), .HALT_ON_ILLEGAL(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  mc_control_fsm #(.MEM_WAIT(3), .HALT_ON_ILLEGAL(0))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  mc_control_fsm #(.MEM_WAIT(0), .HALT_ON_ILLEGAL(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));

  wire [19:0] o1 = {if1.MemWrite, if1.IRWrite,
    if1.RegWrite, if1.PCWrite, if1.PCWriteCond,
    if1.BranchNe, if1.IorD, if1.RegDst, if1.MemtoReg,
    if1.ALUSrcA, if1.ALUOp, if1.PCSource, if1.ALUSrcB};
  wire [19:0] o3 = {if3.MemWrite, if3.IRWrite,
    if3.RegWrite, if3.PCWrite, if3.PCWriteCond,
    if3.BranchNe, if3.IorD, if3.RegDst, if3.MemtoReg,
    if3.ALUSrcA, if3.ALUOp, if3.PCSource, if3.ALUSrcB};

  task automatic restart(input logic [5:0] o,
                         input logic [5:0] f);
    op  = o;
    fn  = f;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if (if1.state_dbg !== S_IDLE || o1 !== '0 ||
        if1.illegal_op !== 1'b0) begin
      nerr++;
      $display("FAIL reset_u1: st=%0d o=%h ill=%b want 0",
               if1.state_dbg, o1, if1.illegal_op);
    end
    nchk++;
    if (if3.state_dbg !== S_IDLE || o3 !== '0) begin
      nerr++;
      $display("FAIL reset_u3: st=%0d o=%h want 0",
               if3.state_dbg, o3);
    end
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if (if1.state_dbg !== S_IDLE || o1 !== '0) begin
      nerr++;
      $display("FAIL reset_release: st=%0d o=%h want 0",
               if1.state_dbg, o1);
    end
  endtask

  task automatic test_addi();
    state_t e [7];
    e = '{S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE,
          S_EXEC_I, S_WB_I, S_FETCH};
    restart(OP_ADDI, 6'd0);
    for (int i = 0; i < 7; i++) begin
      nchk++;
      if (if1.state_dbg !== e[i]) begin
        nerr++;
        $display("FAIL addi_seq[%0d]: st=%0d want %0d",
                 i, if1.state_dbg, e[i]);
      end
      if (i == 1) begin
        nchk++;
        if (o1 !== 20'b0101000_00_00_00_00_00_001) begin
          nerr++;
          $display("FAIL fetch_ctl: o=%b want IR/PC/B4",
                   o1);
        end
      end
      if (i == 4) begin
        nchk++;
        if ({if1.ALUSrcA, if1.ALUSrcB, if1.ALUOp} !==
            {2'd1, 3'd2, 2'd3}) begin
          nerr++;
          $display("FAIL exec_i: a=%0d b=%0d op=%0d want 1 2 3",
                   if1.ALUSrcA, if1.ALUSrcB, if1.ALUOp);
        end
      end
      if (i == 5) begin
        nchk++;
        if (if1.RegWrite !== 1'b1 || if1.RegDst !== 2'd0) begin
          nerr++;
          $display("FAIL wb_i: rw=%b dst=%0d want 1 0",
                   if1.RegWrite, if1.RegDst);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait3();
    state_t e [13];
    int n;
    e = '{S_IDLE, S_FETCH, S_FETCH_WAIT, S_FETCH_WAIT,
          S_FETCH_WAIT, S_DECODE, S_EXEC_MEM, S_MEM_RD,
          S_MEM_WAIT, S_MEM_WAIT, S_MEM_WAIT, S_WB_MEM,
          S_FETCH};
    n = 0;
    restart(OP_LW, 6'd0);
    for (int i = 0; i < 13; i++) begin
      nchk++;
      if (if3.state_dbg !== e[i]) begin
        nerr++;
        $display("FAIL lw3_seq[%0d]: st=%0d want %0d",
                 i, if3.state_dbg, e[i]);
      end
      if (i >= 7 && i <= 10) begin
        nchk++;
        if (if3.IorD !== 1'b1 || if3.MemWrite !== 1'b0) begin
          nerr++;
          $display("FAIL lw3_iord[%0d]: iord=%b mw=%b want 1 0",
                   i, if3.IorD, if3.MemWrite);
        end
      end
      if (i == 11) begin
        nchk++;
        if (if3.MemtoReg !== 2'd1 || if3.RegWrite !== 1'b1) begin
          nerr++;
          $display("FAIL wb_mem: m2r=%0d rw=%b want 1 1",
                   if3.MemtoReg, if3.RegWrite);
        end
      end
      if (i >= 1 && n >= 0) begin
        n++;
        if (if3.state_dbg === S_WB_MEM) begin
          nchk++;
          if (n !== 11) begin
            nerr++;
            $display("FAIL lw3_len: cycles=%0d want 11", n);
          end
          n = -1;
        end
      end
      @(negedge clk);
    end
    nchk++;
    if (n !== -1) begin
      nerr++;
      $display("FAIL lw3_timeout: WB_MEM not reached, n=%0d", n);
    end
  endtask

  task automatic test_sw();
    int mw;
    int rw;
    int multi;
    mw = 0; rw = 0; multi = 0;
    restart(OP_SW, 6'd0);
    for (int i = 0; i < 8; i++) begin
      if (if1.MemWrite === 1'b1) mw++;
      if (if1.RegWrite === 1'b1) rw++;
      if (int'(if1.MemWrite) + int'(if1.RegWrite) +
          int'(if1.IRWrite) > 1) multi++;
      if (i == 5) begin
        nchk++;
        if (if1.state_dbg !== S_MEM_WR || if1.IorD !== 1'b1) begin
          nerr++;
          $display("FAIL sw_memwr: st=%0d iord=%b want %0d 1",
                   if1.state_dbg, if1.IorD, S_MEM_WR);
        end
      end
      if (i == 7) begin
        nchk++;
        if (if1.state_dbg !== S_FETCH) begin
          nerr++;
          $display("FAIL sw_return: st=%0d want %0d",
                   if1.state_dbg, S_FETCH);
        end
      end
      @(negedge clk);
    end
    nchk++;
    if (mw !== 1 || rw !== 0 || multi !== 0) begin
      nerr++;
      $display("FAIL sw_strobes: mw=%0d rw=%0d multi=%0d want 1 0 0",
               mw, rw, multi);
    end
  endtask

  task automatic test_rtype();
    restart(OP_RTYPE, F_SLL);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_EXEC_R || if1.ALUSrcA !== 2'd2 ||
        if1.ALUSrcB !== 3'd4 || if1.ALUOp !== 2'd2) begin
      nerr++;
      $display("FAIL sll_exec: st=%0d a=%0d b=%0d op=%0d want %0d 2 4 2",
               if1.state_dbg, if1.ALUSrcA, if1.ALUSrcB,
               if1.ALUOp, S_EXEC_R);
    end
    @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_WB_R || if1.RegDst !== 2'd1 ||
        if1.RegWrite !== 1'b1) begin
      nerr++;
      $display("FAIL wb_r: st=%0d dst=%0d rw=%b want %0d 1 1",
               if1.state_dbg, if1.RegDst, if1.RegWrite, S_WB_R);
    end
    restart(OP_RTYPE, F_ADD);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_EXEC_R || if1.ALUSrcA !== 2'd1 ||
        if1.ALUSrcB !== 3'd0) begin
      nerr++;
      $display("FAIL add_exec: st=%0d a=%0d b=%0d want %0d 1 0",
               if1.state_dbg, if1.ALUSrcA, if1.ALUSrcB, S_EXEC_R);
    end
    restart(OP_RTYPE, F_JR);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_JR || if1.PCSource !== 2'd3 ||
        if1.PCWrite !== 1'b1) begin
      nerr++;
      $display("FAIL jr: st=%0d pcs=%0d pcw=%b want %0d 3 1",
               if1.state_dbg, if1.PCSource, if1.PCWrite, S_JR);
    end
  endtask

  task automatic test_branch_jal();
    restart(OP_BNE, 6'd0);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_BRANCH || if1.PCWriteCond !== 1'b1 ||
        if1.BranchNe !== 1'b1 || if1.PCSource !== 2'd1 ||
        if1.ALUOp !== 2'd1) begin
      nerr++;
      $display("FAIL bne: st=%0d pwc=%b ne=%b pcs=%0d op=%0d",
               if1.state_dbg, if1.PCWriteCond, if1.BranchNe,
               if1.PCSource, if1.ALUOp);
    end
    restart(OP_BEQ, 6'd0);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_BRANCH || if1.BranchNe !== 1'b0) begin
      nerr++;
      $display("FAIL beq: st=%0d ne=%b want %0d 0",
               if1.state_dbg, if1.BranchNe, S_BRANCH);
    end
    restart(OP_JAL, 6'd0);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_JAL_WB || if1.RegDst !== 2'd2 ||
        if1.MemtoReg !== 2'd2 || if1.RegWrite !== 1'b1) begin
      nerr++;
      $display("FAIL jal_wb: st=%0d dst=%0d m2r=%0d rw=%b",
               if1.state_dbg, if1.RegDst, if1.MemtoReg,
               if1.RegWrite);
    end
    @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_JUMP || if1.PCSource !== 2'd2 ||
        if1.PCWrite !== 1'b1) begin
      nerr++;
      $display("FAIL jal_jump: st=%0d pcs=%0d pcw=%b want %0d 2 1",
               if1.state_dbg, if1.PCSource, if1.PCWrite, S_JUMP);
    end
    @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_FETCH) begin
      nerr++;
      $display("FAIL jal_ret: st=%0d want %0d",
               if1.state_dbg, S_FETCH);
    end
  endtask

  task automatic test_illegal();
    restart(6'b111111, 6'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        nchk++;
        if (if1.illegal_op !== 1'b0) begin
          nerr++;
          $display("FAIL ill_early: ill=%b want 0", if1.illegal_op);
        end
      end
      if (i == 4 || i == 9) begin
        nchk++;
        if (if1.state_dbg !== S_HALT || if1.illegal_op !== 1'b1 ||
            o1 !== '0) begin
          nerr++;
          $display("FAIL halt[%0d]: st=%0d ill=%b o=%h want %0d 1 0",
                   i, if1.state_dbg, if1.illegal_op, o1, S_HALT);
        end
      end
      if (i == 6) begin
        nchk++;
        if (if3.state_dbg !== S_FETCH || if3.illegal_op !== 1'b1) begin
          nerr++;
          $display("FAIL ill_refetch: st=%0d ill=%b want %0d 1",
                   if3.state_dbg, if3.illegal_op, S_FETCH);
        end
      end
      @(negedge clk);
    end
    restart(OP_RTYPE, 6'b111111);
    repeat (4) @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_HALT || if1.illegal_op !== 1'b1) begin
      nerr++;
      $display("FAIL bad_funct: st=%0d ill=%b want %0d 1",
               if1.state_dbg, if1.illegal_op, S_HALT);
    end
  endtask

  task automatic test_nowait();
    state_t ea [6];
    state_t el [7];
    ea = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_I, S_WB_I,
           S_FETCH};
    el = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_MEM, S_MEM_RD,
           S_WB_MEM, S_FETCH};
    restart(OP_ORI, 6'd0);
    for (int i = 0; i < 6; i++) begin
      nchk++;
      if (if0.state_dbg !== ea[i]) begin
        nerr++;
        $display("FAIL w0_ori[%0d]: st=%0d want %0d",
                 i, if0.state_dbg, ea[i]);
      end
      @(negedge clk);
    end
    restart(OP_LW, 6'd0);
    for (int i = 0; i < 7; i++) begin
      nchk++;
      if (if0.state_dbg !== el[i]) begin
        nerr++;
        $display("FAIL w0_lw[%0d]: st=%0d want %0d",
                 i, if0.state_dbg, el[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_memwr();
    restart(OP_SW, 6'd0);
    repeat (5) @(negedge clk);
    nchk++;
    if (if1.MemWrite !== 1'b1) begin
      nerr++;
      $display("FAIL abort_pre: mw=%b want 1", if1.MemWrite);
    end
    #2;
    rst = 1'b1;
    #1;
    nchk++;
    if (if1.MemWrite !== 1'b0 || if1.state_dbg !== S_IDLE ||
        o1 !== '0) begin
      nerr++;
      $display("FAIL abort_async: mw=%b st=%0d o=%h want 0 %0d 0",
               if1.MemWrite, if1.state_dbg, o1, S_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (if1.state_dbg !== S_FETCH) begin
      nerr++;
      $display("FAIL abort_restart: st=%0d want %0d",
               if1.state_dbg, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait3();
    test_sw();
    test_rtype();
    test_branch_jal();
    test_illegal();
    test_nowait();
    test_reset_mid_memwr();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
